// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner
//   Scans a 4x4 CHIP-8 hex keypad and debounces every key independently.
//   Each column is driven low for SCAN_DIV cycles. On the last cycle of that
//   window, the synchronized rows are sampled and the four keys of that column
//   are debounced. A key flips only after DEBOUNCE_SCANS consecutive samples
//   disagree with its stable state.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   row_in     : keypad rows, active-low, asynchronous to clock
//   col_out    : column drive, active-low one-hot
//   keys       : debounced key state, bit k = hex key k held
//   key_press  : one-cycle strobe when any key goes released->pressed
//   key_code   : hex code of the key behind the latest key_press
module chip8_keypad_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS) + 1;

  // Hex code of the key at row r, column c on the standard CHIP-8 layout.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hC;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hD;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'h0;  4'hE: code = 4'hB;  default: code = 4'hF;
    endcase
    return code;
  endfunction

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      keys_q, keys_d;
  logic             key_press_q, key_press_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];

  // Scratch values for the per-row debounce loop.
  logic [3:0]       scan_key;
  logic             scan_raw;
  logic             press_found;

  always_comb begin
    sync1_d     = row_in;
    sync2_d     = sync1_q;
    div_d       = div_q + DIV_W'(1);
    col_d       = col_q;
    keys_d      = keys_q;
    key_press_d = 1'b0;
    key_code_d  = key_code_q;
    cnt_d       = cnt_q;
    scan_key    = 4'h0;
    scan_raw    = 1'b0;
    press_found = 1'b0;

    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      col_d = col_q + 2'd1;
      // Ascending row order so the lowest row claims key_code when several
      // keys of this column are accepted on the same sample.
      for (int r = 0; r < 4; r++) begin
        scan_key = key_map(2'(r), col_q);
        scan_raw = ~sync2_q[r];
        if (scan_raw == keys_q[scan_key]) begin
          cnt_d[scan_key] = '0;
        end else if (cnt_q[scan_key] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
          keys_d[scan_key] = scan_raw;
          cnt_d[scan_key]  = '0;
          if (scan_raw && !press_found) begin
            press_found = 1'b1;
            key_press_d = 1'b1;
            key_code_d  = scan_key;
          end
        end else begin
          cnt_d[scan_key] = cnt_q[scan_key] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      div_q       <= '0;
      col_q       <= 2'd0;
      keys_q      <= 16'h0000;
      key_press_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_q       <= div_d;
      col_q       <= col_d;
      keys_q      <= keys_d;
      key_press_q <= key_press_d;
      key_code_q  <= key_code_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_cnt
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  // Column drive follows the index directly, so it moves on the sample edge.
  assign col_out   = ~(4'b0001 << col_q);
  assign keys      = keys_q;
  assign key_press = key_press_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
module tb_chip8_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_press;
  logic [3:0]  key_code;

  logic [15:0] pressed;
  int          cyc;
  int          press_cnt;
  int          checks;
  int          errors;

  chip8_keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .keys     (keys),
    .key_press(key_press),
    .key_code (key_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] key_at(input int r, input int c);
    logic [3:0] tbl [4][4];
    tbl = '{'{4'h1, 4'h2, 4'h3, 4'hC},
            '{4'h4, 4'h5, 4'h6, 4'hD},
            '{4'h7, 4'h8, 4'h9, 4'hE},
            '{4'hA, 4'h0, 4'hB, 4'hF}};
    return tbl[r][c];
  endfunction

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[key_at(r, c)] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset && key_press) press_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Advance to just after the edge that samples column c (edge 4*(c+1) mod 16).
  task automatic run_to_sample(input int c);
    tick();
    while ((cyc % 16) != ((4 * c + 4) % 16)) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] exp_cols [5];
    exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    pressed   = 16'h0000;
    cyc       = 0;
    press_cnt = 0;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;

    // 1: idle scan
    repeat (3) tick();
    reset = 1'b0;
    cyc   = 0;
    chk("reset_keys", 32'(keys), 32'h0);
    chk("reset_press", 32'(key_press), 32'h0);
    chk("reset_code", 32'(key_code), 32'h0);
    chk("col_0", 32'(col_out), 32'(exp_cols[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (4) tick();
      chk($sformatf("col_%0d", i), 32'(col_out), 32'(exp_cols[i]));
    end
    chk("idle_keys", 32'(keys), 32'h0);
    chk("idle_press_cnt", 32'(press_cnt), 32'h0);

    // 2: hold key 5
    pressed[5] = 1'b1;
    run_to_sample(1);
    chk("k5_s1", 32'(keys), 32'h0);
    run_to_sample(1);
    chk("k5_s2", 32'(keys), 32'h0);
    run_to_sample(1);
    chk("k5_s3_keys", 32'(keys), 32'h0020);
    chk("k5_s3_press", 32'(key_press), 32'h1);
    chk("k5_s3_code", 32'(key_code), 32'h5);
    tick();
    chk("k5_press_drop", 32'(key_press), 32'h0);
    repeat (40) tick();
    chk("k5_press_cnt", 32'(press_cnt), 32'h1);
    chk("k5_hold_keys", 32'(keys), 32'h0020);

    // 3: glitch key C for two scans
    pressed[12] = 1'b1;
    run_to_sample(3);
    run_to_sample(3);
    chk("kc_glitch_keys", 32'(keys), 32'h0020);
    pressed[12] = 1'b0;
    run_to_sample(3);
    chk("kc_release_keys", 32'(keys), 32'h0020);
    chk("kc_glitch_press_cnt", 32'(press_cnt), 32'h1);

    // 5: release key 5
    pressed[5] = 1'b0;
    run_to_sample(1);
    run_to_sample(1);
    chk("k5_rel_s2", 32'(keys), 32'h0020);
    run_to_sample(1);
    chk("k5_rel_s3", 32'(keys), 32'h0000);
    chk("k5_rel_press", 32'(key_press), 32'h0);
    chk("k5_rel_code", 32'(key_code), 32'h5);
    chk("k5_rel_press_cnt", 32'(press_cnt), 32'h1);

    // 3 (cont.): a fresh press of C needs three full samples
    pressed[12] = 1'b1;
    run_to_sample(3);
    run_to_sample(3);
    chk("kc_fresh_s2", 32'(keys), 32'h0000);
    run_to_sample(3);
    chk("kc_fresh_s3", 32'(keys), 32'h1000);
    chk("kc_fresh_code", 32'(key_code), 32'hC);
    pressed[12] = 1'b0;
    repeat (3) run_to_sample(3);
    chk("kc_fresh_rel", 32'(keys), 32'h0000);
    chk("kc_press_cnt", 32'(press_cnt), 32'h2);

    // 4: keys 1 and 7 together, lowest row wins the code
    pressed[1] = 1'b1;
    pressed[7] = 1'b1;
    repeat (2) run_to_sample(0);
    chk("k17_s2", 32'(keys), 32'h0000);
    run_to_sample(0);
    chk("k17_keys", 32'(keys), 32'h0082);
    chk("k17_press", 32'(key_press), 32'h1);
    chk("k17_code", 32'(key_code), 32'h1);
    tick();
    chk("k17_press_cnt", 32'(press_cnt), 32'h3);
    pressed[1] = 1'b0;
    pressed[7] = 1'b0;
    repeat (3) run_to_sample(0);
    chk("k17_rel", 32'(keys), 32'h0000);

    // 6: reset while key 0 is mid-debounce
    pressed[0] = 1'b1;
    repeat (2) run_to_sample(1);
    chk("k0_pre_reset", 32'(keys), 32'h0000);
    tick();
    reset = 1'b1;
    tick();
    chk("k0_reset_keys", 32'(keys), 32'h0000);
    chk("k0_reset_col", 32'(col_out), 32'b1110);
    chk("k0_reset_press", 32'(key_press), 32'h0);
    reset = 1'b0;
    cyc   = 0;
    run_to_sample(1);
    chk("k0_s1", 32'(keys), 32'h0000);
    run_to_sample(1);
    chk("k0_s2", 32'(keys), 32'h0000);
    run_to_sample(1);
    chk("k0_s3", 32'(keys), 32'h0001);
    chk("k0_code", 32'(key_code), 32'h0);
    tick();
    chk("k0_press_cnt", 32'(press_cnt), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
